// File: rtl/pid_sched_pkg.sv
// rtl/pid_sched_pkg.sv - shared state encoding and counter sizing for the PID sample scheduler
package pid_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TRIGGER,
      WAIT_MEAS,
      UPDATE,
      CAPTURE,
      FAULT
   } sched_state_t;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tick_generator.sv
// rtl/tick_generator.sv - free-running sample period counter, preloaded so the first enabled cycle ticks
module tick_generator
   import pid_sched_pkg::*;
#(
   parameter int PERIOD = 5_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int              W    = cnt_width(PERIOD);
   localparam logic [W-1:0]    LAST = W'(PERIOD - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!enable)
         cnt_d = LAST;
      else if (cnt_q == LAST)
         cnt_d = '0;
      else
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= LAST;
      else
         cnt_q <= cnt_d;
   end

   assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/pid_sample_scheduler.sv
// rtl/pid_sample_scheduler.sv - sequences sensor measurement, PID strobe and control capture per sample tick
module pid_sample_scheduler
   import pid_sched_pkg::*;
#(
   parameter int SAMPLE_PERIOD_CYCLES = 5_000_000,
   parameter int TIMEOUT_CYCLES       = 3_000_000,
   parameter int MAX_MISSES           = 3,
   parameter int PV_WIDTH             = 9,
   parameter int CONTROL_WIDTH        = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            enable,
   output logic                            meas_req,
   input  logic                            meas_valid,
   input  logic        [PV_WIDTH-1:0]      meas_data,
   output logic        [PV_WIDTH-1:0]      pid_feedback,
   output logic                            pid_clk_en,
   output logic                            pid_en,
   input  logic signed [CONTROL_WIDTH-1:0] pid_control,
   output logic signed [CONTROL_WIDTH-1:0] control_hold,
   output logic                            control_valid,
   output logic                            fault,
   output logic                            overrun,
   output logic        [1:0]               miss_count
);

   localparam int           TW      = cnt_width(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic tick;

   tick_generator #(
      .PERIOD (SAMPLE_PERIOD_CYCLES)
   ) u_tick (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .tick   (tick)
   );

   sched_state_t                     state_q, state_d;
   logic        [TW-1:0]             to_cnt_q, to_cnt_d;
   logic                             meas_req_q, meas_req_d;
   logic                             pid_clk_en_q, pid_clk_en_d;
   logic                             pid_en_q, pid_en_d;
   logic                             control_valid_q, control_valid_d;
   logic                             fault_q, fault_d;
   logic                             overrun_q, overrun_d;
   logic        [1:0]                miss_q, miss_d;
   logic        [PV_WIDTH-1:0]       feedback_q, feedback_d;
   logic signed [CONTROL_WIDTH-1:0]  hold_q, hold_d;

   always_comb begin
      state_d         = state_q;
      to_cnt_d        = to_cnt_q;
      control_valid_d = 1'b0;
      overrun_d       = overrun_q;
      miss_d          = miss_q;
      feedback_d      = feedback_q;
      hold_d          = hold_q;

      if (!enable) begin
         state_d    = IDLE;
         to_cnt_d   = '0;
         overrun_d  = 1'b0;
         miss_d     = '0;
         feedback_d = '0;
         hold_d     = '0;
      end else begin
         if (tick && state_q != IDLE && state_q != FAULT)
            overrun_d = 1'b1;

         case (state_q)
            IDLE: begin
               if (tick)
                  state_d = TRIGGER;
            end
            TRIGGER: begin
               to_cnt_d = '0;
               state_d  = WAIT_MEAS;
            end
            WAIT_MEAS: begin
               // A result arriving on the expiry cycle still counts as a good sample.
               if (meas_valid) begin
                  feedback_d = meas_data;
                  miss_d     = '0;
                  state_d    = UPDATE;
               end else if (to_cnt_q == TO_LAST) begin
                  miss_d  = miss_q + 2'd1;
                  state_d = (miss_d == 2'(MAX_MISSES)) ? FAULT : IDLE;
               end else begin
                  to_cnt_d = to_cnt_q + TW'(1);
               end
            end
            UPDATE: begin
               state_d = CAPTURE;
            end
            CAPTURE: begin
               hold_d          = pid_control;
               control_valid_d = 1'b1;
               state_d         = IDLE;
            end
            FAULT: begin
               state_d = FAULT;
            end
            default: begin
               state_d = IDLE;
            end
         endcase

         if (state_d == FAULT)
            hold_d = '0;
      end

      meas_req_d   = (state_d == TRIGGER);
      pid_clk_en_d = (state_d == UPDATE);
      fault_d      = (state_d == FAULT);
      pid_en_d     = enable && (state_d != FAULT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         to_cnt_q        <= '0;
         meas_req_q      <= 1'b0;
         pid_clk_en_q    <= 1'b0;
         pid_en_q        <= 1'b0;
         control_valid_q <= 1'b0;
         fault_q         <= 1'b0;
         overrun_q       <= 1'b0;
         miss_q          <= '0;
         feedback_q      <= '0;
         hold_q          <= '0;
      end else begin
         state_q         <= state_d;
         to_cnt_q        <= to_cnt_d;
         meas_req_q      <= meas_req_d;
         pid_clk_en_q    <= pid_clk_en_d;
         pid_en_q        <= pid_en_d;
         control_valid_q <= control_valid_d;
         fault_q         <= fault_d;
         overrun_q       <= overrun_d;
         miss_q          <= miss_d;
         feedback_q      <= feedback_d;
         hold_q          <= hold_d;
      end
   end

   assign meas_req      = meas_req_q;
   assign pid_feedback  = feedback_q;
   assign pid_clk_en    = pid_clk_en_q;
   assign pid_en        = pid_en_q;
   assign control_hold  = hold_q;
   assign control_valid = control_valid_q;
   assign fault         = fault_q;
   assign overrun       = overrun_q;
   assign miss_count    = miss_q;

endmodule

// File: tb/tb_pid_sample_scheduler.sv
// tb/tb_pid_sample_scheduler.sv - directed bench for pid_sample_scheduler
module tb_pid_sample_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset;
   logic               enable, meas_valid;
   logic [8:0]         meas_data;
   logic signed [15:0] pid_control;
   logic               meas_req, pid_clk_en, pid_en, control_valid, fault, overrun;
   logic [8:0]         pid_feedback;
   logic signed [15:0] control_hold;
   logic [1:0]         miss_count;

   logic               enable_b, meas_valid_b;
   logic [8:0]         meas_data_b;
   logic signed [15:0] pid_control_b;
   logic               meas_req_b, pid_clk_en_b, pid_en_b, control_valid_b, fault_b, overrun_b;
   logic [8:0]         pid_feedback_b;
   logic signed [15:0] control_hold_b;
   logic [1:0]         miss_count_b;

   int n_cmp = 0;
   int n_bad = 0;

   pid_sample_scheduler #(
      .SAMPLE_PERIOD_CYCLES (20), .TIMEOUT_CYCLES (8), .MAX_MISSES (3),
      .PV_WIDTH (9), .CONTROL_WIDTH (16)
   ) dut (
      .clk (clk), .reset (reset), .enable (enable),
      .meas_req (meas_req), .meas_valid (meas_valid), .meas_data (meas_data),
      .pid_feedback (pid_feedback), .pid_clk_en (pid_clk_en), .pid_en (pid_en),
      .pid_control (pid_control), .control_hold (control_hold),
      .control_valid (control_valid), .fault (fault), .overrun (overrun),
      .miss_count (miss_count)
   );

   // Short period so a tick lands while the sensor is still being waited on.
   pid_sample_scheduler #(
      .SAMPLE_PERIOD_CYCLES (6), .TIMEOUT_CYCLES (8), .MAX_MISSES (3),
      .PV_WIDTH (9), .CONTROL_WIDTH (16)
   ) dut_ovr (
      .clk (clk), .reset (reset), .enable (enable_b),
      .meas_req (meas_req_b), .meas_valid (meas_valid_b), .meas_data (meas_data_b),
      .pid_feedback (pid_feedback_b), .pid_clk_en (pid_clk_en_b), .pid_en (pid_en_b),
      .pid_control (pid_control_b), .control_hold (control_hold_b),
      .control_valid (control_valid_b), .fault (fault_b), .overrun (overrun_b),
      .miss_count (miss_count_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input string name, output int cycles);
      cycles = 0;
      while (!meas_req && cycles < 60) begin
         step();
         cycles++;
      end
      n_cmp++; if (meas_req !== 1'b1) begin n_bad++; $display("FAIL %s_wait got meas_req=%b want 1 within 60 cycles", name, meas_req); end
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; meas_valid = 1'b0; meas_data = '0; pid_control = '0;
      enable_b = 1'b0; meas_valid_b = 1'b0; meas_data_b = '0; pid_control_b = '0;
      step(); step();
      reset = 1'b0;
      step();
      n_cmp++; if ({meas_req, pid_clk_en, pid_en, control_valid, fault, overrun} !== 6'b0) begin n_bad++; $display("FAIL reset_flags got %b want 000000", {meas_req, pid_clk_en, pid_en, control_valid, fault, overrun}); end
      n_cmp++; if (pid_feedback !== 9'd0) begin n_bad++; $display("FAIL reset_feedback got %0d want 0", pid_feedback); end
      n_cmp++; if (control_hold !== 16'sd0) begin n_bad++; $display("FAIL reset_hold got %0d want 0", control_hold); end
      n_cmp++; if (miss_count !== 2'd0) begin n_bad++; $display("FAIL reset_miss got %0d want 0", miss_count); end
   endtask

   task automatic test_nominal();
      int n;
      int pulses;
      enable = 1'b1; pid_control = -16'sd420;
      step();
      n_cmp++; if (meas_req !== 1'b1) begin n_bad++; $display("FAIL nom_first_req got %b want 1", meas_req); end
      n_cmp++; if (pid_en !== 1'b1) begin n_bad++; $display("FAIL nom_pid_en got %b want 1", pid_en); end
      n = 0;
      step(); step(); n += 2;
      meas_valid = 1'b1; meas_data = 9'd150;
      step(); n++;
      meas_valid = 1'b0; meas_data = 9'd0;
      pulses = int'(pid_clk_en);
      n_cmp++; if (pid_clk_en !== 1'b1) begin n_bad++; $display("FAIL nom_clk_en got %b want 1", pid_clk_en); end
      n_cmp++; if (pid_feedback !== 9'd150) begin n_bad++; $display("FAIL nom_feedback got %0d want 150", pid_feedback); end
      step(); n++;
      n_cmp++; if (control_valid !== 1'b0) begin n_bad++; $display("FAIL nom_valid_early got %b want 0", control_valid); end
      step(); n++;
      n_cmp++; if (control_valid !== 1'b1) begin n_bad++; $display("FAIL nom_valid got %b want 1", control_valid); end
      n_cmp++; if (control_hold !== -16'sd420) begin n_bad++; $display("FAIL nom_hold got %0d want -420", control_hold); end
      step(); n++;
      n_cmp++; if (control_valid !== 1'b0) begin n_bad++; $display("FAIL nom_valid_pulse got %b want 0", control_valid); end
      while (!meas_req && n < 40) begin
         step(); n++;
         pulses += int'(pid_clk_en);
      end
      n_cmp++; if (meas_req !== 1'b1 || n !== 20) begin n_bad++; $display("FAIL nom_period got %0d cycles (req=%b) want 20", n, meas_req); end
      n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL nom_clk_en_count got %0d want 1", pulses); end
   endtask

   task automatic test_timeout();
      int pulses;
      int c;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         pulses += int'(pid_clk_en);
      end
      n_cmp++; if (miss_count !== 2'd0) begin n_bad++; $display("FAIL to_early got miss=%0d want 0", miss_count); end
      step();
      pulses += int'(pid_clk_en);
      n_cmp++; if (miss_count !== 2'd1) begin n_bad++; $display("FAIL to_miss got %0d want 1", miss_count); end
      n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL to_no_update got %0d pulses want 0", pulses); end
      n_cmp++; if (pid_feedback !== 9'd150) begin n_bad++; $display("FAIL to_feedback_held got %0d want 150", pid_feedback); end
      wait_req("to_next", c);
      step();
      meas_valid = 1'b1; meas_data = 9'd80;
      step();
      meas_valid = 1'b0; meas_data = 9'd0;
      n_cmp++; if (miss_count !== 2'd0) begin n_bad++; $display("FAIL to_recover_miss got %0d want 0", miss_count); end
      n_cmp++; if (pid_feedback !== 9'd80) begin n_bad++; $display("FAIL to_recover_feedback got %0d want 80", pid_feedback); end
      step(); step(); step();
   endtask

   task automatic test_race();
      int c;
      wait_req("race", c);
      repeat (8) step();
      meas_valid = 1'b1; meas_data = 9'd200;
      step();
      meas_valid = 1'b0; meas_data = 9'd0;
      n_cmp++; if (pid_feedback !== 9'd200) begin n_bad++; $display("FAIL race_feedback got %0d want 200", pid_feedback); end
      n_cmp++; if (miss_count !== 2'd0) begin n_bad++; $display("FAIL race_miss got %0d want 0", miss_count); end
      n_cmp++; if (pid_clk_en !== 1'b1) begin n_bad++; $display("FAIL race_clk_en got %b want 1", pid_clk_en); end
      step(); step(); step();
   endtask

   task automatic test_fault();
      int c;
      int reqs;
      for (int k = 0; k < 3; k++) begin
         wait_req("fault", c);
         repeat (9) step();
         n_cmp++; if (miss_count !== 2'(k + 1)) begin n_bad++; $display("FAIL fault_miss%0d got %0d want %0d", k, miss_count, k + 1); end
         n_cmp++; if (fault !== (k == 2)) begin n_bad++; $display("FAIL fault_flag%0d got %b want %b", k, fault, (k == 2)); end
      end
      n_cmp++; if (pid_en !== 1'b0) begin n_bad++; $display("FAIL fault_pid_en got %b want 0", pid_en); end
      n_cmp++; if (control_hold !== 16'sd0) begin n_bad++; $display("FAIL fault_hold got %0d want 0", control_hold); end
      reqs = 0;
      repeat (45) begin
         step();
         reqs += int'(meas_req);
      end
      n_cmp++; if (reqs !== 0 || fault !== 1'b1) begin n_bad++; $display("FAIL fault_sticky got reqs=%0d fault=%b want 0/1", reqs, fault); end
      enable = 1'b0;
      step();
      n_cmp++; if (fault !== 1'b0 || miss_count !== 2'd0) begin n_bad++; $display("FAIL fault_clear got fault=%b miss=%0d want 0/0", fault, miss_count); end
      enable = 1'b1;
      step();
      n_cmp++; if (meas_req !== 1'b1 || pid_en !== 1'b1) begin n_bad++; $display("FAIL fault_restart got req=%b pid_en=%b want 1/1", meas_req, pid_en); end
   endtask

   task automatic test_abort();
      int c;
      int pulses;
      pid_control = 16'sd123;
      step();
      meas_valid = 1'b1; meas_data = 9'd33;
      step();
      meas_valid = 1'b0; meas_data = 9'd0;
      step(); step();
      n_cmp++; if (control_valid !== 1'b1 || control_hold !== 16'sd123) begin n_bad++; $display("FAIL abort_pre_hold got %0d (v=%b) want 123", control_hold, control_valid); end
      meas_valid = 1'b1; meas_data = 9'd444;
      pulses = 0;
      repeat (2) begin
         step();
         pulses += int'(pid_clk_en);
      end
      meas_valid = 1'b0; meas_data = 9'd0;
      n_cmp++; if (pid_feedback !== 9'd33 || pulses !== 0) begin n_bad++; $display("FAIL stray_valid got fb=%0d pulses=%0d want 33/0", pid_feedback, pulses); end
      wait_req("abort", c);
      step();
      meas_valid = 1'b1; meas_data = 9'd77;
      step();
      n_cmp++; if (pid_clk_en !== 1'b1) begin n_bad++; $display("FAIL abort_in_update got %b want 1", pid_clk_en); end
      enable = 1'b0; meas_data = 9'd99;
      step();
      n_cmp++; if ({pid_clk_en, pid_en, control_valid} !== 3'b000) begin n_bad++; $display("FAIL abort_flags got %b want 000", {pid_clk_en, pid_en, control_valid}); end
      n_cmp++; if (control_hold !== 16'sd0 || pid_feedback !== 9'd0) begin n_bad++; $display("FAIL abort_regs got hold=%0d fb=%0d want 0/0", control_hold, pid_feedback); end
      step();
      meas_valid = 1'b0; meas_data = 9'd0;
      n_cmp++; if (pid_feedback !== 9'd0 || meas_req !== 1'b0) begin n_bad++; $display("FAIL abort_idle got fb=%0d req=%b want 0/0", pid_feedback, meas_req); end
   endtask

   task automatic test_overrun();
      enable_b = 1'b1;
      step();
      n_cmp++; if (meas_req_b !== 1'b1) begin n_bad++; $display("FAIL ovr_req got %b want 1", meas_req_b); end
      repeat (5) step();
      n_cmp++; if (overrun_b !== 1'b0) begin n_bad++; $display("FAIL ovr_early got %b want 0", overrun_b); end
      step();
      n_cmp++; if (overrun_b !== 1'b1) begin n_bad++; $display("FAIL ovr_set got %b want 1", overrun_b); end
      repeat (10) step();
      n_cmp++; if (overrun_b !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky got %b want 1", overrun_b); end
      enable_b = 1'b0;
      step();
      n_cmp++; if (overrun_b !== 1'b0) begin n_bad++; $display("FAIL ovr_clear got %b want 0", overrun_b); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_nominal();
      test_timeout();
      test_race();
      test_fault();
      test_abort();
      test_overrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
